qdr_traffic_gen: RTL

Parametrised QDRII+ traffic generator and checker that drives the MIG QDRII user interface (port 0) after calibration. It replaces the fixed example traffic generator used in the QDR bring-up bench. It adds:
- configurable width, burst length and pass length;
- selectable data patterns;
- bounded outstanding reads;
- error counting with first-failure capture;
- read timeout detection.

It sits between board/bench control and the MIG user interface and produces the `tg_compare_error` and status signals.

---
 rtl/qdr_traffic_gen.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/qdr_traffic_gen.sv
// QDRII+ traffic generator/checker for MIG user port 0.
// Optional `QDR_TG_ERR_INJECT_EN adds inject_err (one-shot bit-0 flip on next write).
module qdr_traffic_gen #(
  parameter int DATA_WIDTH      = 36,
  parameter int ADDR_WIDTH      = 18,
  parameter int BW_WIDTH        = 4,
  parameter int BURST_LEN       = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT_CYC     = 4096,
  parameter int ERR_CNT_W       = 16
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic                            init_calib_complete,
  input  logic                            start,
  input  logic                            continuous,
  input  logic                            stop,
  input  logic [1:0]                      mode,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [ADDR_WIDTH-1:0]           num_words,
`ifdef QDR_TG_ERR_INJECT_EN
  input  logic                            inject_err,
`endif
  output logic                            app_wr_cmd0,
  output logic [ADDR_WIDTH-1:0]           app_wr_addr0,
  output logic [DATA_WIDTH*BURST_LEN-1:0] app_wr_data0,
  output logic [BW_WIDTH*BURST_LEN-1:0]   app_wr_bw_n0,
  output logic                            app_rd_cmd0,
  output logic [ADDR_WIDTH-1:0]           app_rd_addr0,
  input  logic                            app_rd_valid0,
  input  logic [DATA_WIDTH*BURST_LEN-1:0] app_rd_data0,
  output logic                            busy,
  output logic                            done,
  output logic                            tg_compare_error,
  output logic                            timeout,
  output logic [ERR_CNT_W-1:0]            err_cnt,
  output logic [ADDR_WIDTH-1:0]           first_err_addr,
  output logic [15:0]                     pass_cnt
);

  localparam int APP_W = DATA_WIDTH * BURST_LEN;
  localparam int PW    = $clog2(APP_W);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic [2:0]            state;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] last_q;
  logic                  cont_q;
  logic                  stop_q;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0] ck_idx;
  logic [31:0]           wr_lfsr;
  logic [31:0]           ck_lfsr;
  logic [PW-1:0]         wr_pos;
  logic [PW-1:0]         ck_pos;
  logic [OW-1:0]         outst;
  logic [TW-1:0]         to_cnt;

  function automatic logic [APP_W-1:0] rep32(
    input logic [31:0] s
  );
    logic [APP_W-1:0] w;
    for (int b = 0; b < APP_W; b++) w[b] = s[b % 32];
    return w;
  endfunction

  function automatic logic [APP_W-1:0] pat(
    input logic [1:0]            m,
    input logic [ADDR_WIDTH-1:0] i,
    input logic [31:0]           lf,
    input logic [PW-1:0]         pos
  );
    logic [APP_W-1:0] w;
    w = '0;
    unique case (m)
      2'd0:    w = rep32(32'(i));
      2'd1:    w[pos] = 1'b1;
      2'd2:    w = rep32(lf);
      default: w = {APP_W{i[0]}};
    endcase
    return w;
  endfunction

  function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [PW-1:0] pos_nx(input logic [PW-1:0] p);
    return (p == PW'(APP_W - 1)) ? '0 : p + PW'(1);
  endfunction

  logic             in_rd;
  logic             rd_acc;
  logic             dec;
  logic             rd_ok;
  logic             mism;
  logic             to_hit;
  logic             calib_lost;
  logic             inj_flip;
  logic [APP_W-1:0] wr_word;
  logic [APP_W-1:0] ck_word;

  assign in_rd      = (state == S_READ) || (state == S_WAIT);
  assign rd_acc     = in_rd && app_rd_valid0;
  assign dec        = rd_acc && ((outst != '0) || app_rd_cmd0);
  assign rd_ok      = ({1'b0, outst} + {{OW{1'b0}}, app_rd_cmd0})
                      < (OW+1)'(MAX_OUTSTANDING);
  assign wr_word    = pat(mode_q, wr_idx, wr_lfsr, wr_pos);
  assign ck_word    = pat(mode_q, ck_idx, ck_lfsr, ck_pos);
  assign mism       = rd_acc && (app_rd_data0 != ck_word);
  assign to_hit     = in_rd && (outst != '0) && !app_rd_valid0
                      && (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign calib_lost = busy && !init_calib_complete;
  assign app_wr_bw_n0 = '0;

`ifdef QDR_TG_ERR_INJECT_EN
  logic inj_armed;
  assign inj_flip = inj_armed && (state == S_WRITE);
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)   inj_armed <= 1'b0;
    else if (inj_flip) inj_armed <= inject_err;
    else if (inject_err) inj_armed <= 1'b1;
  end
`else
  assign inj_flip = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state            <= S_IDLE;
      mode_q           <= '0;
      base_q           <= '0;
      last_q           <= '0;
      cont_q           <= 1'b0;
      stop_q           <= 1'b0;
      wr_idx           <= '0;
      rd_idx           <= '0;
      ck_idx           <= '0;
      wr_lfsr          <= SEED;
      ck_lfsr          <= SEED;
      wr_pos           <= '0;
      ck_pos           <= '0;
      outst            <= '0;
      to_cnt           <= '0;
      app_wr_cmd0      <= 1'b0;
      app_wr_addr0     <= '0;
      app_wr_data0     <= '0;
      app_rd_cmd0      <= 1'b0;
      app_rd_addr0     <= '0;
      tg_compare_error <= 1'b0;
      timeout          <= 1'b0;
      err_cnt          <= '0;
      first_err_addr   <= '0;
      pass_cnt         <= '0;
    end else begin
      app_wr_cmd0 <= 1'b0;
      app_rd_cmd0 <= 1'b0;
      if (busy && stop) stop_q <= 1'b1;

      if (app_rd_cmd0 && !dec)      outst <= outst + OW'(1);
      else if (dec && !app_rd_cmd0) outst <= outst - OW'(1);

      if (in_rd && (outst != '0) && !app_rd_valid0)
        to_cnt <= to_cnt + TW'(1);
      else
        to_cnt <= '0;

      if (rd_acc) begin
        ck_idx  <= ck_idx + ADDR_WIDTH'(1);
        ck_lfsr <= lfsr_nx(ck_lfsr);
        ck_pos  <= pos_nx(ck_pos);
      end
      if (mism) begin
        tg_compare_error <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
        if (!tg_compare_error) first_err_addr <= base_q + ck_idx;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start && init_calib_complete) begin
            state            <= S_WRITE;
            mode_q           <= mode;
            base_q           <= base_addr;
            last_q           <= (num_words == '0) ? '0
                                : num_words - ADDR_WIDTH'(1);
            cont_q           <= continuous;
            stop_q           <= 1'b0;
            wr_idx           <= '0;
            rd_idx           <= '0;
            ck_idx           <= '0;
            wr_lfsr          <= SEED;
            ck_lfsr          <= SEED;
            wr_pos           <= '0;
            ck_pos           <= '0;
            tg_compare_error <= 1'b0;
            timeout          <= 1'b0;
            err_cnt          <= '0;
            first_err_addr   <= '0;
            pass_cnt         <= '0;
          end
        end
        S_WRITE: begin
          app_wr_cmd0  <= 1'b1;
          app_wr_addr0 <= base_q + wr_idx;
          app_wr_data0 <= wr_word ^ {{(APP_W-1){1'b0}}, inj_flip};
          wr_idx       <= wr_idx + ADDR_WIDTH'(1);
          wr_lfsr      <= lfsr_nx(wr_lfsr);
          wr_pos       <= pos_nx(wr_pos);
          if (wr_idx == last_q) state <= S_READ;
        end
        S_READ: begin
          if (rd_ok) begin
            app_rd_cmd0  <= 1'b1;
            app_rd_addr0 <= base_q + rd_idx;
            rd_idx       <= rd_idx + ADDR_WIDTH'(1);
            if (rd_idx == last_q) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if ((outst == '0) && !app_rd_cmd0) begin
            pass_cnt <= pass_cnt + 16'd1;
            stop_q   <= 1'b0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            ck_idx   <= '0;
            wr_lfsr  <= SEED;
            ck_lfsr  <= SEED;
            wr_pos   <= '0;
            ck_pos   <= '0;
            if (cont_q && !stop_q && !stop) state <= S_WRITE;
            else                            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Abort paths drop whatever is in flight; late returns are ignored in DONE.
      if (to_hit || calib_lost) begin
        timeout     <= 1'b1;
        state       <= S_DONE;
        outst       <= '0;
        to_cnt      <= '0;
        app_wr_cmd0 <= 1'b0;
        app_rd_cmd0 <= 1'b0;
      end
    end
  end

endmodule
